paddle_ctrl: RTL and testbench

- Parametrised next-generation paddle controller for the pong datapath.
- Outputs the upper-left X/Y of one paddle, with screen, wall, paddle and ball geometry set by parameters.
- Supports three modes (manual, AI track, AI centre) and a speed ramp, so a paddle held in one direction accelerates.
- Position updates only on a frame-rate tick strobe, never on every clk.
- One instance per side, fed by the keyboard decoder and the ball block.

---
 rtl/pong_pkg.sv | 31 +++
 rtl/paddle_speed_ramp.sv | 86 ++++++++
 rtl/paddle_ctrl.sv | 168 ++++++++++++++++
 tb/tb_paddle_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared constants and enumerations for the pong paddle datapath.
// Screen and wall defaults here seed the paddle_ctrl parameters.
package pong_pkg;

    localparam int SCREEN_W_DEF   = 640;
    localparam int SCREEN_H_DEF   = 480;
    localparam int WALL_W_DEF     = 8;
    localparam int PADDLE_W_DEF   = 16;
    localparam int PADDLE_LEN_DEF = 64;
    localparam int BALL_W_DEF     = 8;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'd0,
        MODE_TRACK  = 2'd1,
        MODE_CENTRE = 2'd2,
        MODE_HOLD   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RAMP   = 2'd1,
        CRUISE = 2'd2
    } ramp_state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        UP   = 2'd1,
        DN   = 2'd2
    } dir_e;

endpackage

// File: rtl/paddle_speed_ramp.sv
// Speed ramp FSM for one paddle: owns speed, the acceleration counter and IDLE/RAMP/CRUISE.
// step_o is the displacement to apply on the current tick; speed_o is the registered speed.
module paddle_speed_ramp
    import pong_pkg::*;
#(
    parameter int SPEED_MIN   = 2,
    parameter int SPEED_MAX   = 8,
    parameter int ACCEL_TICKS = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tick_i,
    input  dir_e       dir_req_i,
    input  logic       blocked_i,
    input  logic       force_idle_i,
    input  logic       no_ramp_i,
    output logic [3:0] step_o,
    output logic [3:0] speed_o
);

    localparam logic [3:0] SMIN  = 4'(SPEED_MIN);
    localparam logic [3:0] SMAX  = 4'(SPEED_MAX);
    localparam logic [7:0] ACCEL = 8'(ACCEL_TICKS);

    ramp_state_e state_q, state_d, state_cur;
    dir_e        dir_q, dir_d;
    logic [3:0]  speed_q, speed_d, speed_cur, speed_base, speed_inc;
    logic [7:0]  cnt_q, cnt_d, cnt_cur, cnt_base, cnt_inc;
    logic        restart;

    // A mode change acts as if the FSM were already idle; starting or reversing restarts at SPEED_MIN.
    always_comb begin
        state_cur  = force_idle_i ? IDLE : state_q;
        speed_cur  = force_idle_i ? SMIN : speed_q;
        cnt_cur    = force_idle_i ? 8'd0 : cnt_q;
        restart    = (state_cur == IDLE) || (dir_req_i != dir_q);
        speed_base = restart ? SMIN : speed_cur;
        cnt_base   = restart ? 8'd0 : cnt_cur;
        cnt_inc    = cnt_base + 8'd1;
        speed_inc  = (cnt_inc == ACCEL) ? speed_base + 4'd1 : speed_base;
        step_o     = no_ramp_i ? SMIN : speed_base;
    end

    always_comb begin
        state_d = state_q;
        speed_d = speed_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        if (tick_i) begin
            if (dir_req_i == NONE || no_ramp_i) begin
                state_d = IDLE;
                speed_d = SMIN;
                cnt_d   = 8'd0;
                dir_d   = NONE;
            end else if (blocked_i) begin
                state_d = state_cur;
                speed_d = speed_cur;
                cnt_d   = cnt_cur;
            end else if (state_cur == CRUISE && !restart) begin
                state_d = CRUISE;
            end else begin
                dir_d   = dir_req_i;
                speed_d = speed_inc;
                cnt_d   = (cnt_inc == ACCEL) ? 8'd0 : cnt_inc;
                state_d = (speed_inc >= SMAX) ? CRUISE : RAMP;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            speed_q <= SMIN;
            cnt_q   <= 8'd0;
            dir_q   <= NONE;
        end else begin
            state_q <= state_d;
            speed_q <= speed_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    assign speed_o = speed_q;

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle position controller: manual / AI track / AI centre / hold, clamped between the walls.
// Define PADDLE_AI_PREDICT_EN to aim AI tracking at a predicted ball intercept.
module paddle_ctrl
    import pong_pkg::*;
#(
    parameter int SCREEN_W    = SCREEN_W_DEF,
    parameter int SCREEN_H    = SCREEN_H_DEF,
    parameter int PADDLE_W    = PADDLE_W_DEF,
    parameter int PADDLE_LEN  = PADDLE_LEN_DEF,
    parameter int WALL_W      = WALL_W_DEF,
    parameter int BALL_W      = BALL_W_DEF,
    parameter int SPEED_MIN   = 2,
    parameter int SPEED_MAX   = 8,
    parameter int ACCEL_TICKS = 4,
    parameter int DEADBAND    = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tick_i,
    input  logic       side_i,
    input  logic [1:0] mode_i,
    input  logic       up_i,
    input  logic       down_i,
    input  logic [9:0] ball_x_i,
    input  logic [8:0] ball_y_i,
    input  logic       ball_dir_i,
    output logic [9:0] out_x_o,
    output logic [8:0] out_y_o,
    output logic       moving_o,
    output logic       at_limit_o,
    output logic [3:0] speed_o
);

    localparam logic [10:0] Y_TOP     = 11'(WALL_W);
    localparam logic [10:0] Y_BOT     = 11'(SCREEN_H - WALL_W - PADDLE_LEN);
    localparam logic [10:0] Y_RST     = 11'((SCREEN_H - PADDLE_LEN) / 2);
    localparam logic [10:0] HALF_LEN  = 11'(PADDLE_LEN / 2);
    localparam logic [10:0] HALF_BALL = 11'(BALL_W / 2);
    localparam logic [10:0] MID_Y     = 11'(SCREEN_H / 2);
    localparam logic [10:0] DB        = 11'(DEADBAND);
    localparam logic [9:0]  X_RIGHT   = 10'(SCREEN_W - PADDLE_W);

    logic [8:0]  y_q;
    logic [1:0]  mode_q;
    logic        moving_q, at_limit_q, side_q, side_eff;
    logic [10:0] y_ext, pc, tc, tc_ball, y_up, y_dn, y_next, step_ext;
    logic [3:0]  step;
    logic        track_ball, centre, blocked;
    dir_e        dir_req;

    // Side is followed live during reset and frozen once reset releases.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            side_q <= side_i;
        end
    end
    assign side_eff = rst_ni ? side_q : side_i;
    assign out_x_o  = side_eff ? 10'd0 : X_RIGHT;

`ifdef PADDLE_AI_PREDICT_EN
    localparam logic signed [20:0] PW_S  = 21'(PADDLE_W);
    localparam logic signed [20:0] XR_S  = 21'(SCREEN_W - PADDLE_W - BALL_W);
    localparam logic signed [20:0] TOP_S = 21'(WALL_W);
    localparam logic signed [20:0] BOT_S = 21'(SCREEN_H - WALL_W - BALL_W);

    logic [8:0]         ball_y_prev_q;
    logic signed [20:0] delta, dist, proj;
    logic [10:0]        pred_y;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ball_y_prev_q <= 9'd0;
        end else if (tick_i) begin
            ball_y_prev_q <= ball_y_i;
        end
    end

    always_comb begin
        delta = $signed({12'd0, ball_y_i}) - $signed({12'd0, ball_y_prev_q});
        dist  = side_eff ? ($signed({11'd0, ball_x_i}) - PW_S)
                         : (XR_S - $signed({11'd0, ball_x_i}));
        if (dist < 21'sd0) begin
            dist = 21'sd0;
        end
        proj = $signed({12'd0, ball_y_i}) + delta * (dist >>> 3);
        if (proj < TOP_S) begin
            pred_y = 11'(WALL_W);
        end else if (proj > BOT_S) begin
            pred_y = 11'(SCREEN_H - WALL_W - BALL_W);
        end else begin
            pred_y = proj[10:0];
        end
        tc_ball = pred_y + HALF_BALL;
    end
`else
    logic unused_ball_x;
    assign unused_ball_x = ^ball_x_i;
    assign tc_ball       = {2'b00, ball_y_i} + HALF_BALL;
`endif

    // Request direction, then the clamped move for this tick's step.
    always_comb begin
        y_ext      = {2'b00, y_q};
        pc         = y_ext + HALF_LEN;
        track_ball = (mode_i == MODE_TRACK) && (ball_dir_i == side_eff);
        centre     = (mode_i == MODE_CENTRE) || ((mode_i == MODE_TRACK) && !track_ball);
        tc         = track_ball ? tc_ball : MID_Y;
        dir_req    = NONE;
        if (mode_i == MODE_MANUAL) begin
            if (up_i && !down_i) begin
                dir_req = UP;
            end else if (down_i && !up_i) begin
                dir_req = DN;
            end
        end else if (mode_i != MODE_HOLD) begin
            if (pc > tc + DB) begin
                dir_req = UP;
            end else if (pc + DB < tc) begin
                dir_req = DN;
            end
        end
        step_ext = {7'd0, step};
        y_up     = (y_ext < Y_TOP + step_ext) ? Y_TOP : y_ext - step_ext;
        y_dn     = (y_ext + step_ext > Y_BOT) ? Y_BOT : y_ext + step_ext;
        y_next   = y_ext;
        if (dir_req == UP) begin
            y_next = y_up;
        end else if (dir_req == DN) begin
            y_next = y_dn;
        end
        blocked = (dir_req != NONE) && (y_next == y_ext);
    end

    paddle_speed_ramp #(
        .SPEED_MIN  (SPEED_MIN),
        .SPEED_MAX  (SPEED_MAX),
        .ACCEL_TICKS(ACCEL_TICKS)
    ) u_ramp (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .tick_i      (tick_i),
        .dir_req_i   (dir_req),
        .blocked_i   (blocked),
        .force_idle_i(mode_i != mode_q),
        .no_ramp_i   (centre),
        .step_o      (step),
        .speed_o     (speed_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            y_q        <= Y_RST[8:0];
            mode_q     <= MODE_MANUAL;
            moving_q   <= 1'b0;
            at_limit_q <= 1'b0;
        end else if (tick_i) begin
            y_q        <= y_next[8:0];
            mode_q     <= mode_i;
            moving_q   <= (dir_req != NONE) && !blocked;
            at_limit_q <= (y_next == Y_TOP) || (y_next == Y_BOT);
        end
    end

    assign out_y_o    = y_q;
    assign moving_o   = moving_q;
    assign at_limit_o = at_limit_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Scoreboard bench for paddle_ctrl: stimulus pushes expected outputs, monitors pop them
// after every tick edge and after every reset assertion.
module tb_paddle_ctrl;

    logic       clk     = 1'b0;
    logic       rstN    = 1'b1;
    logic       tick    = 1'b0;
    logic       side    = 1'b0;
    logic [1:0] mode    = 2'd0;
    logic       up      = 1'b0;
    logic       down    = 1'b0;
    logic [9:0] ballX   = 10'd320;
    logic [8:0] ballY   = 9'd200;
    logic       ballDir = 1'b0;
    logic [9:0] outX;
    logic [8:0] outY;
    logic       moving, atLimit;
    logic [3:0] speed;

    typedef struct {
        string      name;
        logic [9:0] x;
        logic [8:0] y;
        logic       mv;
        logic       lim;
        logic [3:0] spd;
    } exp_t;

    exp_t       expQ[$];
    int         vectorsApplied = 0;
    int         miscompares    = 0;
    logic [9:0] expX           = 10'd624;

    paddle_ctrl dut (
        .clk_i     (clk),
        .rst_ni    (rstN),
        .tick_i    (tick),
        .side_i    (side),
        .mode_i    (mode),
        .up_i      (up),
        .down_i    (down),
        .ball_x_i  (ballX),
        .ball_y_i  (ballY),
        .ball_dir_i(ballDir),
        .out_x_o   (outX),
        .out_y_o   (outY),
        .moving_o  (moving),
        .at_limit_o(atLimit),
        .speed_o   (speed)
    );

    always #5 clk = ~clk;

    task automatic checkOutput();
        exp_t e;
        vectorsApplied++;
        if (expQ.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL unexpected_output at %0t: got y=%0d, no expected entry", $time, outY);
            return;
        end
        e = expQ.pop_front();
        if (outX !== e.x || outY !== e.y || moving !== e.mv || atLimit !== e.lim || speed !== e.spd) begin
            miscompares++;
            $display("[TB] FAIL %s: got x=%0d y=%0d moving=%0b at_limit=%0b speed=%0d, expected x=%0d y=%0d moving=%0b at_limit=%0b speed=%0d",
                     e.name, outX, outY, moving, atLimit, speed, e.x, e.y, e.mv, e.lim, e.spd);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (tick === 1'b1) begin
                #1;
                checkOutput();
            end
        end
    end

    initial begin
        forever begin
            @(negedge rstN);
            #1;
            checkOutput();
        end
    end

    task automatic pushExp(input string name, input logic [8:0] ey, input logic emv,
                           input logic elim, input logic [3:0] espd);
        exp_t e;
        e.name = name;
        e.x    = expX;
        e.y    = ey;
        e.mv   = emv;
        e.lim  = elim;
        e.spd  = espd;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input string name, input logic u, input logic d, input logic [1:0] m,
                                 input logic [8:0] ey, input logic emv, input logic elim,
                                 input logic [3:0] espd);
        @(negedge clk);
        up   = u;
        down = d;
        mode = m;
        pushExp(name, ey, emv, elim, espd);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic doReset(input string name, input logic s);
        expX = s ? 10'd0 : 10'd624;
        pushExp(name, 9'd208, 1'b0, 1'b0, 4'd2);
        @(posedge clk);
        #3;
        side = s;
        rstN = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        up   = 1'b0;
        down = 1'b0;
        mode = 2'd0;
        rstN = 1'b1;
    endtask

    function automatic int stepFor(input int k);
        int s;
        s = 2 + (k - 1) / 4;
        return (s > 8) ? 8 : s;
    endfunction

    function automatic int speedAfter(input int k);
        int s;
        s = 2 + k / 4;
        return (s > 8) ? 8 : s;
    endfunction

    initial begin
        int y;
        int yTrack[17]   = '{210, 212, 214, 216, 219, 222, 225, 228, 232, 236, 240, 244, 249, 254, 259, 264, 270};
        int spdTrack[17] = '{2, 2, 2, 3, 3, 3, 3, 4, 4, 4, 4, 5, 5, 5, 5, 6, 6};

        #2;
        doReset("reset_side0", 1'b0);

        y = 208;
        for (int k = 1; k <= 25; k++) begin
            y -= stepFor(k);
            applyStimulus($sformatf("ramp_up_%0d", k), 1'b1, 1'b0, 2'd0, 9'(y), 1'b1, 1'b0, 4'(speedAfter(k)));
        end
        applyStimulus("reverse_down", 1'b0, 1'b1, 2'd0, 9'd94, 1'b1, 1'b0, 4'd2);
        applyStimulus("release", 1'b0, 1'b0, 2'd0, 9'd94, 1'b0, 1'b0, 4'd2);

        y = 94;
        while (y > 10) begin
            y -= 2;
            applyStimulus($sformatf("tap_up_%0d", y), 1'b1, 1'b0, 2'd0, 9'(y), 1'b1, 1'b0, 4'd2);
            applyStimulus($sformatf("tap_rel_%0d", y), 1'b0, 1'b0, 2'd0, 9'(y), 1'b0, 1'b0, 4'd2);
        end
        applyStimulus("clamp_top", 1'b1, 1'b0, 2'd0, 9'd8, 1'b1, 1'b1, 4'd2);
        applyStimulus("blocked_top_1", 1'b1, 1'b0, 2'd0, 9'd8, 1'b0, 1'b1, 4'd2);
        applyStimulus("blocked_top_2", 1'b1, 1'b0, 2'd0, 9'd8, 1'b0, 1'b1, 4'd2);
        applyStimulus("hold_mode", 1'b1, 1'b0, 2'd3, 9'd8, 1'b0, 1'b1, 4'd2);

        doReset("reset_side1", 1'b1);
        ballDir = 1'b1;
        ballY   = 9'd300;
        for (int k = 0; k < 17; k++) begin
            applyStimulus($sformatf("track_dn_%0d", k + 1), 1'b0, 1'b0, 2'd1, 9'(yTrack[k]), 1'b1, 1'b0, 4'(spdTrack[k]));
        end
        applyStimulus("track_settle", 1'b0, 1'b0, 2'd1, 9'd270, 1'b0, 1'b0, 4'd2);

        ballDir = 1'b0;
        y = 270;
        for (int k = 1; k <= 30; k++) begin
            y -= 2;
            applyStimulus($sformatf("drift_centre_%0d", k), 1'b0, 1'b0, 2'd1, 9'(y), 1'b1, 1'b0, 4'd2);
        end
        applyStimulus("drift_settle", 1'b0, 1'b0, 2'd1, 9'd210, 1'b0, 1'b0, 4'd2);
        applyStimulus("centre_mode", 1'b0, 1'b0, 2'd2, 9'd210, 1'b0, 1'b0, 4'd2);

        doReset("reset_side0_again", 1'b0);
        y = 208;
        for (int k = 1; k <= 12; k++) begin
            y -= stepFor(k);
            applyStimulus($sformatf("midramp_%0d", k), 1'b1, 1'b0, 2'd0, 9'(y), 1'b1, 1'b0, 4'(speedAfter(k)));
        end
        doReset("async_reset_midramp", 1'b0);
        applyStimulus("post_reset_idle", 1'b0, 1'b0, 2'd0, 9'd208, 1'b0, 1'b0, 4'd2);

        for (int i = 0; i < 50 && expQ.size() != 0; i++) begin
            @(posedge clk);
        end
        if (expQ.size() != 0) begin
            $display("[TB] FAIL drain_timeout: got %0d unchecked entries, expected 0", expQ.size());
            miscompares += expQ.size();
        end
        #20;
        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
